// File: rtl/exc_ctrl.sv
// MEM-stage exception/interrupt prioritiser with a CP0 subset (BadVAddr, Status, Cause, EPC).
// Accepted events raise a registered one-cycle flush and redirect PC; irq inputs are synchronised first.
module exc_ctrl #(
    parameter int          NUM_IRQ     = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        excep_type,
    input  logic               adel,
    input  logic               ades,
    input  logic               valid_m,
    input  logic               stall_m,
    input  logic [31:0]        pc_m,
    input  logic               in_delay_slot,
    input  logic [31:0]        badaddr_m,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_waddr,
    input  logic [31:0]        cp0_wdata,
    input  logic [4:0]         cp0_raddr,
    output logic [31:0]        cp0_rdata,
    output logic [4:0]         exc_code,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               status_exl
);
    localparam logic [4:0] EC_INT  = 5'd0;
    localparam logic [4:0] EC_ADEL = 5'd4;
    localparam logic [4:0] EC_ADES = 5'd5;
    localparam logic [4:0] EC_SYS  = 5'd8;
    localparam logic [4:0] EC_BP   = 5'd9;
    localparam logic [4:0] EC_RI   = 5'd10;
    localparam logic [4:0] EC_OV   = 5'd12;
    localparam logic [4:0] EC_ERET = 5'd14;
    localparam logic [4:0] EC_NONE = 5'h1f;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] irq_sync_q, irq_sync_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] epc_q, epc_d;
    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [1:0]  ip_sw_q, ip_sw_d;
    logic [4:0]  cause_code_q, cause_code_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [4:0]  exc_code_q, exc_code_d;

    logic [5:0]  ip_hw;
    logic [7:0]  ip;
    logic        int_pend;
    logic        has_cause;
    logic        accept;
    logic [4:0]  code;
    logic        unused_excep;

    assign unused_excep = ^{excep_type[31:15], excep_type[13], excep_type[11],
                            excep_type[7:6], excep_type[3:0]};

    always_comb begin
        irq_sync_d[0] = irq;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            irq_sync_d[i] = irq_sync_q[i-1];
        end
    end

    // The last synchroniser stage is the hardware part of Cause.IP.
    always_comb begin
        ip_hw = '0;
        ip_hw[NUM_IRQ-1:0] = irq_sync_q[SYNC_STAGES-1];
    end

    assign ip       = {ip_hw, ip_sw_q};
    assign int_pend = (|(ip & im_q)) & ie_q & ~exl_q;

    always_comb begin
        has_cause = 1'b1;
        code      = EC_NONE;
        if (int_pend)                          code = EC_INT;
        else if (excep_type[4] | adel)         code = EC_ADEL;
        else if (excep_type[5] | ades)         code = EC_ADES;
        else if (excep_type[8])                code = EC_SYS;
        else if (excep_type[9])                code = EC_BP;
        else if (excep_type[10])               code = EC_RI;
        else if (excep_type[12])               code = EC_OV;
        else if (excep_type[14])               code = EC_ERET;
        else                                   has_cause = 1'b0;
    end

    assign accept = valid_m & ~stall_m & ~flush_q & has_cause;

    always_comb begin
        badvaddr_d   = badvaddr_q;
        epc_d        = epc_q;
        im_d         = im_q;
        exl_d        = exl_q;
        ie_d         = ie_q;
        bd_d         = bd_q;
        ip_sw_d      = ip_sw_q;
        cause_code_d = cause_code_q;
        flush_d      = accept;
        new_pc_d     = new_pc_q;
        exc_code_d   = exc_code_q;

        if (cp0_we) begin
            case (cp0_waddr)
                CP0_STATUS: begin
                    im_d  = cp0_wdata[15:8];
                    exl_d = cp0_wdata[1];
                    ie_d  = cp0_wdata[0];
                end
                CP0_CAUSE: ip_sw_d = cp0_wdata[9:8];
                CP0_EPC:   epc_d   = cp0_wdata;
                default: ;
            endcase
        end

        // Event updates come after the MTC0 write so they win field by field.
        if (accept) begin
            exc_code_d = code;
            if (code == EC_ERET) begin
                exl_d    = 1'b0;
                new_pc_d = epc_q;
            end else begin
                cause_code_d = code;
                exl_d        = 1'b1;
                new_pc_d     = EXC_VECTOR;
                if (!exl_q) begin
                    epc_d = in_delay_slot ? (pc_m - 32'd4) : pc_m;
                    bd_d  = in_delay_slot;
                end
                if (code == EC_ADEL)      badvaddr_d = excep_type[4] ? pc_m : badaddr_m;
                else if (code == EC_ADES) badvaddr_d = badaddr_m;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_sync_q   <= '0;
            badvaddr_q   <= '0;
            epc_q        <= '0;
            im_q         <= '0;
            exl_q        <= 1'b0;
            ie_q         <= 1'b0;
            bd_q         <= 1'b0;
            ip_sw_q      <= '0;
            cause_code_q <= '0;
            flush_q      <= 1'b0;
            new_pc_q     <= '0;
            exc_code_q   <= EC_NONE;
        end else begin
            irq_sync_q   <= irq_sync_d;
            badvaddr_q   <= badvaddr_d;
            epc_q        <= epc_d;
            im_q         <= im_d;
            exl_q        <= exl_d;
            ie_q         <= ie_d;
            bd_q         <= bd_d;
            ip_sw_q      <= ip_sw_d;
            cause_code_q <= cause_code_d;
            flush_q      <= flush_d;
            new_pc_q     <= new_pc_d;
            exc_code_q   <= exc_code_d;
        end
    end

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_STATUS:   cp0_rdata = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
            CP0_CAUSE:    cp0_rdata = {bd_q, 15'b0, ip, 1'b0, cause_code_q, 2'b0};
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign flush      = flush_q;
    assign new_pc     = new_pc_q;
    assign exc_code   = exc_code_q;
    assign status_exl = exl_q;
endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed scenarios then random traffic, all checked against a CP0 model.
module tb_exc_ctrl;
    localparam int          NUM_IRQ = 6;
    localparam int          SYNC    = 2;
    localparam logic [31:0] VEC     = 32'hBFC00380;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        excep_type;
    logic               adel, ades, valid_m, stall_m, in_delay_slot;
    logic [31:0]        pc_m, badaddr_m;
    logic [NUM_IRQ-1:0] irq;
    logic               cp0_we;
    logic [4:0]         cp0_waddr, cp0_raddr;
    logic [31:0]        cp0_wdata, cp0_rdata;
    logic [4:0]         exc_code;
    logic               flush;
    logic [31:0]        new_pc;
    logic               status_exl;

    exc_ctrl #(.NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .rst(rst), .excep_type(excep_type), .adel(adel), .ades(ades),
        .valid_m(valid_m), .stall_m(stall_m), .pc_m(pc_m), .in_delay_slot(in_delay_slot),
        .badaddr_m(badaddr_m), .irq(irq), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .exc_code(exc_code), .flush(flush), .new_pc(new_pc), .status_exl(status_exl)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state kept as whole architectural register words.
    logic [31:0]        m_badv, m_status, m_cause, m_epc, m_newpc;
    logic               m_flush;
    logic [4:0]         m_code;
    logic [NUM_IRQ-1:0] irq_hist [SYNC];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd12:   return m_status;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_badv = 0; m_status = 32'h0040_0000; m_cause = 0; m_epc = 0;
        m_newpc = 0; m_flush = 0; m_code = 5'h1f;
        for (int k = 0; k < SYNC; k++) irq_hist[k] = '0;
    endtask

    task automatic model_step();
        logic [31:0] st, ca, ep, bv;
        logic [14:0] pres;
        int          code;
        bit          acc;
        st = m_status; ca = m_cause; ep = m_epc; bv = m_badv;
        pres     = '0;
        pres[0]  = ((m_cause[15:8] & m_status[15:8]) != 8'h0) && m_status[0] && !m_status[1];
        pres[4]  = excep_type[4] | adel;
        pres[5]  = excep_type[5] | ades;
        pres[8]  = excep_type[8];
        pres[9]  = excep_type[9];
        pres[10] = excep_type[10];
        pres[12] = excep_type[12];
        pres[14] = excep_type[14];
        // Priority order coincides with ascending exception code.
        code = -1;
        for (int i = 14; i >= 0; i--) if (pres[i]) code = i;
        acc = valid_m && !stall_m && !m_flush && (code >= 0);

        if (cp0_we) begin
            if (cp0_waddr == 5'd12) st = (st & ~32'h0000_FF03) | (cp0_wdata & 32'h0000_FF03);
            if (cp0_waddr == 5'd13) ca[9:8] = cp0_wdata[9:8];
            if (cp0_waddr == 5'd14) ep = cp0_wdata;
        end

        for (int k = SYNC - 1; k > 0; k--) irq_hist[k] = irq_hist[k-1];
        irq_hist[0] = irq;
        ca[15:10] = '0;
        ca[10 +: NUM_IRQ] = irq_hist[SYNC-1];

        m_flush = acc;
        if (acc) begin
            m_code = code[4:0];
            if (code == 14) begin
                st[1]   = 1'b0;
                m_newpc = m_epc;
            end else begin
                ca[6:2] = code[4:0];
                if (!m_status[1]) begin
                    ep     = in_delay_slot ? pc_m - 32'd4 : pc_m;
                    ca[31] = in_delay_slot;
                end
                st[1] = 1'b1;
                if (code == 4) bv = excep_type[4] ? pc_m : badaddr_m;
                if (code == 5) bv = badaddr_m;
                m_newpc = VEC;
            end
        end
        m_status = st; m_cause = ca; m_epc = ep; m_badv = bv;
    endtask

    task automatic compare_all();
        check_val("flush", 32'(flush), 32'(m_flush));
        check_val("new_pc", new_pc, m_newpc);
        check_val("exc_code", 32'(exc_code), 32'(m_code));
        check_val("status_exl", 32'(status_exl), 32'(m_status[1]));
        check_val("cp0_rdata", cp0_rdata, model_read(cp0_raddr));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        excep_type = 0; adel = 0; ades = 0; valid_m = 0; stall_m = 0;
        pc_m = 0; in_delay_slot = 0; badaddr_m = 0; irq = '0;
        cp0_we = 0; cp0_waddr = 0; cp0_wdata = 0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
        tick();
        cp0_we = 0;
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_raddr = a;
        #1;
        check_val(tag, cp0_rdata, exp);
    endtask

    int lat, nflush;

    initial begin
        idle();
        cp0_raddr = 5'd12;
        rst = 0;
        model_reset();
        #2 rst = 1;
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_flush", 32'(flush), 32'h0);
        check_val("rst_code", 32'(exc_code), 32'h1f);
        check_val("rst_status", cp0_rdata, 32'h0040_0000);
        rst = 0;
        tick();

        // Overflow in a delay slot
        excep_type = 32'h1000; pc_m = 32'h8000_0104; in_delay_slot = 1; valid_m = 1;
        tick();
        check_val("ov_flush", 32'(flush), 32'h1);
        check_val("ov_newpc", new_pc, VEC);
        check_val("ov_code", 32'(exc_code), 32'd12);
        check_val("ov_exl", 32'(status_exl), 32'h1);
        idle();
        peek("ov_epc", 5'd14, 32'h8000_0100);
        peek("ov_cause", 5'd13, 32'h8000_0030);

        // Sys together with a data load address error
        mtc0(5'd12, 32'h0);
        excep_type = 32'h100; adel = 1; badaddr_m = 32'h1234_5671; pc_m = 32'h8000_0040; valid_m = 1;
        tick();
        check_val("adel_code", 32'(exc_code), 32'd4);
        idle();
        peek("adel_badv", 5'd8, 32'h1234_5671);
        peek("adel_epc", 5'd14, 32'h8000_0040);

        // Interrupt enabled through IM2
        mtc0(5'd12, 32'h0000_0401);
        irq = 1; valid_m = 1;
        lat = 0;
        for (int t = 1; t <= 8 && lat == 0; t++) begin
            tick();
            if (flush) lat = t;
        end
        check_val("irq_latency", 32'(lat), 32'(SYNC + 1));
        check_val("irq_code", 32'(exc_code), 32'd0);
        peek("irq_cause", 5'd13, 32'h0000_0400);
        idle();
        repeat (SYNC + 1) tick();

        // Same interrupt with IM2 clear
        mtc0(5'd12, 32'h0000_0001);
        irq = 1; valid_m = 1; nflush = 0;
        repeat (SYNC + 4) begin
            tick();
            if (flush) nflush++;
        end
        check_val("irq_masked", 32'(nflush), 32'h0);
        idle();
        repeat (SYNC + 1) tick();

        // ERET
        mtc0(5'd14, 32'h8000_0200);
        mtc0(5'd12, 32'h0000_0002);
        excep_type = 32'h4000; valid_m = 1;
        tick();
        check_val("eret_flush", 32'(flush), 32'h1);
        check_val("eret_newpc", new_pc, 32'h8000_0200);
        check_val("eret_code", 32'(exc_code), 32'h0e);
        check_val("eret_exl", 32'(status_exl), 32'h0);
        idle();
        tick();
        check_val("eret_flush_drop", 32'(flush), 32'h0);
        check_val("newpc_hold", new_pc, 32'h8000_0200);

        // Stall, back-to-back, exception while EXL=1
        excep_type = 32'h200; valid_m = 1; stall_m = 1; pc_m = 32'h8000_0300;
        tick();
        check_val("stall_noflush", 32'(flush), 32'h0);
        stall_m = 0;
        tick();
        check_val("bp_flush", 32'(flush), 32'h1);
        check_val("bp_code", 32'(exc_code), 32'd9);
        excep_type = 32'h400; pc_m = 32'h8000_0400;
        tick();
        check_val("b2b_ignored", 32'(flush), 32'h0);
        check_val("b2b_code_hold", 32'(exc_code), 32'd9);
        tick();
        check_val("exl_exc_code", 32'(exc_code), 32'd10);
        idle();
        peek("epc_exl_kept", 5'd14, 32'h8000_0300);

        // EPC wrap for a delay slot at PC 0
        mtc0(5'd12, 32'h0);
        excep_type = 32'h100; pc_m = 32'h0; in_delay_slot = 1; valid_m = 1;
        tick();
        idle();
        peek("epc_wrap", 5'd14, 32'hFFFF_FFFC);

        // Reset while a flush is pending
        mtc0(5'd12, 32'h0);
        excep_type = 32'h1000; valid_m = 1; pc_m = 32'h8000_0500;
        tick();
        rst = 1;
        #1;
        check_val("rst_cancel_flush", 32'(flush), 32'h0);
        check_val("rst_cancel_code", 32'(exc_code), 32'h1f);
        model_reset();
        idle();
        tick();
        rst = 0;
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            valid_m    = ($urandom_range(0, 3) != 0);
            stall_m    = ($urandom_range(0, 4) == 0);
            excep_type = ($urandom & 32'hFFFF_A8CF) |
                         (($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_5730) : 32'h0);
            adel       = ($urandom_range(0, 9) == 0);
            ades       = ($urandom_range(0, 9) == 0);
            pc_m       = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            in_delay_slot = 1'($urandom_range(0, 1));
            badaddr_m  = $urandom;
            if ($urandom_range(0, 7) == 0) irq = NUM_IRQ'($urandom);
            cp0_we     = ($urandom_range(0, 7) == 0);
            cp0_waddr  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(5'd12 + $urandom_range(0, 2));
            cp0_wdata  = $urandom;
            cp0_raddr  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(5'd8 + 4 * $urandom_range(0, 1) + $urandom_range(0, 2));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
